test_mon: RTL and testbench

Synthesizable test-status monitor and stimulus generator that sits beside `sparrow_soc` and snoops the core's register-file writeback port. It decides pass, fail, software end or timeout for ISA-test and normal programs. It replaces hierarchical peeking and fixed testbench delays, so the same verdict logic runs in simulation and on FPGA. It is generalised over a mode, register indices, timeout width/limit and settle delay, and optionally injects an external-trap pulse.

---
 rtl/test_mon_pkg.sv | 36 +++
 rtl/test_mon_trapgen.sv | 44 ++++
 rtl/test_mon.sv | 183 ++++++++++++++++++
 tb/tb_test_mon.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/test_mon_pkg.sv
// Shared types and constants for the test_mon verdict monitor.
// Holds the run-state enum, verdict codes and default register indices.
package test_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    SETTLE  = 3'd2,
    PASS    = 3'd3,
    FAIL    = 3'd4,
    SWEND   = 3'd5,
    TIMEOUT = 3'd6
  } state_e;

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_PASS  = 3'd1;
  localparam logic [2:0] CODE_FAIL  = 3'd2;
  localparam logic [2:0] CODE_SWEND = 3'd3;
  localparam logic [2:0] CODE_TMO   = 3'd4;

  localparam int DEF_DONE_REG = 26;
  localparam int DEF_RES_REG  = 27;
  localparam int DEF_NUM_REG  = 3;

  // Terminal states hold until reset and freeze all captured values.
  function automatic logic is_terminal(input state_e s);
    return (s == PASS) || (s == FAIL) || (s == SWEND) || (s == TIMEOUT);
  endfunction

  // x0 is hard-wired zero in the core, so writes to it never count.
  function automatic logic reg_hit(input logic we, input logic [4:0] waddr,
                                   input logic [4:0] idx);
    return we && (waddr != 5'd0) && (waddr == idx);
  endfunction

endpackage

// File: rtl/test_mon_trapgen.sv
// External-trap pulse generator: high while the run counter sits in [TRAP_AT, TRAP_AT+TRAP_LEN).
// Fed with next-cycle counter/activity so the registered output lines up with the counter.
module test_mon_trapgen
  import test_mon_pkg::*;
#(
  parameter int TMO_W    = 32,
  parameter int TRAP_AT  = 900,
  parameter int TRAP_LEN = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TMO_W-1:0] cnt_nx,
  input  logic             active_nx,
  output logic             ex_trap_o
);

  localparam int WW = TMO_W + 1;
  localparam logic [WW-1:0] WIN_LO = WW'(TRAP_AT);
  localparam logic [WW-1:0] WIN_HI = WW'(TRAP_AT) + WW'(TRAP_LEN);

  logic in_win_s;
  logic trap_r;

  // Window compare done one bit wider so TRAP_AT+TRAP_LEN cannot wrap.
  always_comb begin
    if (TRAP_LEN == 0) begin
      in_win_s = 1'b0;
    end else begin
      in_win_s = ({1'b0, cnt_nx} >= WIN_LO) && ({1'b0, cnt_nx} < WIN_HI);
    end
  end

  // Registered pulse, suppressed once the run has left RUN/SETTLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_r <= 1'b0;
    end else begin
      trap_r <= active_nx && in_win_s;
    end
  end

  assign ex_trap_o = trap_r;

endmodule

// File: rtl/test_mon.sv
// test_mon: pass/fail/swend/timeout verdict monitor snooping the register-file writeback port.
// Define TEST_MON_TRAPGEN_EN to build the external-trap pulse generator.
module test_mon
  import test_mon_pkg::*;
#(
  parameter int MODE       = 0,
  parameter int DONE_REG   = DEF_DONE_REG,
  parameter int RES_REG    = DEF_RES_REG,
  parameter int NUM_REG    = DEF_NUM_REG,
  parameter int SETTLE_CYC = 10,
  parameter int TMO_W      = 32,
  parameter int TMO_LIMIT  = 30000,
  parameter int TRAP_AT    = 900,
  parameter int TRAP_LEN   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_waddr_i,
  input  logic [31:0]      wb_wdata_i,
  input  logic             mends_i,
  output logic             ex_trap_o,
  output logic             end_o,
  output logic             busy_o,
  output logic [2:0]       code_o,
  output logic [31:0]      fail_num_o,
  output logic [TMO_W-1:0] cycles_o
);

  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TMO_LIMIT - 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_e           state_r, state_nx_s;
  logic [TMO_W-1:0] cnt_r, cnt_nx_s;
  logic [7:0]       settle_cnt_r;
  logic [31:0]      res_q, num_q;
  logic             done_s, tmo_s, settle_done_s;
  logic [2:0]       code_s, code_r;
  logic             busy_s, busy_r, end_s, end_r;

  // Event decode for the current cycle.
  always_comb begin
    done_s        = (MODE == 0) && reg_hit(wb_we_i, wb_waddr_i, 5'(DONE_REG))
                    && (wb_wdata_i == 32'h1);
    tmo_s         = (cnt_r == TMO_LAST);
    settle_done_s = (settle_cnt_r == SETTLE_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; timeout outranks software end, which outranks done.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: state_nx_s = RUN;
      RUN: begin
        if (tmo_s) begin
          state_nx_s = TIMEOUT;
        end else if (mends_i) begin
          state_nx_s = SWEND;
        end else if (done_s) begin
          state_nx_s = SETTLE;
        end else begin
          state_nx_s = RUN;
        end
      end
      SETTLE: begin
        if (tmo_s) begin
          state_nx_s = TIMEOUT;
        end else if (settle_done_s) begin
          state_nx_s = (res_q == 32'd1) ? PASS : FAIL;
        end else begin
          state_nx_s = SETTLE;
        end
      end
      PASS, FAIL, SWEND, TIMEOUT: state_nx_s = state_r;
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs align with it.
  always_comb begin
    code_s = CODE_NONE;
    case (state_nx_s)
      PASS:    code_s = CODE_PASS;
      FAIL:    code_s = CODE_FAIL;
      SWEND:   code_s = CODE_SWEND;
      TIMEOUT: code_s = CODE_TMO;
      default: code_s = CODE_NONE;
    endcase
    busy_s = (state_nx_s == RUN) || (state_nx_s == SETTLE);
    end_s  = is_terminal(state_nx_s) && !is_terminal(state_r);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_r <= CODE_NONE;
      busy_r <= 1'b0;
      end_r  <= 1'b0;
    end else begin
      code_r <= code_s;
      busy_r <= busy_s;
      end_r  <= end_s;
    end
  end

  // Run counter: zero entering RUN, counts through RUN/SETTLE, frozen after.
  always_comb begin
    cnt_nx_s = cnt_r;
    case (state_r)
      IDLE:        cnt_nx_s = '0;
      RUN, SETTLE: cnt_nx_s = cnt_r + TMO_W'(1);
      default:     cnt_nx_s = cnt_r;
    endcase
  end

  // Run counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nx_s;
    end
  end

  // Settle counter is held at zero outside SETTLE so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt_r <= 8'd0;
    end else if (state_r == SETTLE) begin
      settle_cnt_r <= settle_cnt_r + 8'd1;
    end else begin
      settle_cnt_r <= 8'd0;
    end
  end

  // Result/test-number shadows follow writeback until a verdict is reached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= 32'd0;
      num_q <= 32'd0;
    end else if (!is_terminal(state_r)) begin
      if (reg_hit(wb_we_i, wb_waddr_i, 5'(RES_REG))) begin
        res_q <= wb_wdata_i;
      end
      if (reg_hit(wb_we_i, wb_waddr_i, 5'(NUM_REG))) begin
        num_q <= wb_wdata_i;
      end
    end
  end

  assign code_o     = code_r;
  assign busy_o     = busy_r;
  assign end_o      = end_r;
  assign fail_num_o = num_q;
  assign cycles_o   = cnt_r;

`ifdef TEST_MON_TRAPGEN_EN
  test_mon_trapgen #(
    .TMO_W    (TMO_W),
    .TRAP_AT  (TRAP_AT),
    .TRAP_LEN (TRAP_LEN)
  ) u_trapgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt_nx    (cnt_nx_s),
    .active_nx (busy_s),
    .ex_trap_o (ex_trap_o)
  );
`else
  // Trap window parameters only matter with the generator; this is always 0.
  assign ex_trap_o = (TRAP_AT < 0) && (TRAP_LEN < 0);
`endif

endmodule

// File: tb/tb_test_mon.sv
// Self-checking bench for test_mon: directed and randomized runs against an event-level verdict model.
module tb_test_mon;

  localparam int S     = 10;
  localparam int LIM_A = 1000;
  localparam int LIM_B = 201;
  localparam int MAXC  = 1100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, we, mends;
  logic [4:0]  addr;
  logic [31:0] wdata;

  logic        a_trap, a_end, a_busy, b_trap, b_end, b_busy;
  logic [2:0]  a_code, b_code;
  logic [31:0] a_fn, b_fn, a_cyc, b_cyc;

  test_mon #(.MODE(0), .TMO_LIMIT(LIM_A)) u_a (
    .clk(clk), .rst_n(rst_a), .wb_we_i(we), .wb_waddr_i(addr), .wb_wdata_i(wdata),
    .mends_i(mends), .ex_trap_o(a_trap), .end_o(a_end), .busy_o(a_busy),
    .code_o(a_code), .fail_num_o(a_fn), .cycles_o(a_cyc));

  test_mon #(.MODE(1), .TMO_LIMIT(LIM_B)) u_b (
    .clk(clk), .rst_n(rst_b), .wb_we_i(we), .wb_waddr_i(addr), .wb_wdata_i(wdata),
    .mends_i(mends), .ex_trap_o(b_trap), .end_o(b_end), .busy_o(b_busy),
    .code_o(b_code), .fail_num_o(b_fn), .cycles_o(b_cyc));

  bit          sel_r = 1'b0;
  logic        o_trap, o_end, o_busy;
  logic [2:0]  o_code;
  logic [31:0] o_fn, o_cyc;
  assign o_trap = sel_r ? b_trap : a_trap;
  assign o_end  = sel_r ? b_end  : a_end;
  assign o_busy = sel_r ? b_busy : a_busy;
  assign o_code = sel_r ? b_code : a_code;
  assign o_fn   = sel_r ? b_fn   : a_fn;
  assign o_cyc  = sel_r ? b_cyc  : a_cyc;

  // Stimulus tables indexed by run cycle.
  bit          s_we[MAXC];
  logic [4:0]  s_addr[MAXC];
  logic [31:0] s_data[MAXC];
  bit          s_m[MAXC];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      s_we[i] = 1'b0; s_addr[i] = 5'd0; s_data[i] = 32'd0; s_m[i] = 1'b0;
    end
  endtask

  task automatic wr(input int c, input logic [4:0] a, input logic [31:0] d);
    s_we[c] = 1'b1; s_addr[c] = a; s_data[c] = d;
  endtask

  // Reference: walk the run cycle by cycle applying the verdict rules in priority order.
  task automatic model(input int mode, input int lim, output int code, output int e,
                       output logic [31:0] fnum);
    int td;
    logic [31:0] res;
    td = -1; res = 32'd0; code = 0; e = lim;
    for (int c = 0; c < lim; c++) begin
      if (c == lim - 1) begin code = 4; e = c + 1; break; end
      if (td < 0) begin
        if (s_m[c]) begin code = 3; e = c + 1; break; end
        if (mode == 0 && s_we[c] && s_addr[c] == 5'd26 && s_data[c] == 32'd1) td = c;
      end else if (c == td + S) begin
        code = (res == 32'd1) ? 1 : 2; e = c + 1; break;
      end
      if (s_we[c] && s_addr[c] == 5'd27) res = s_data[c];
    end
    fnum = 32'd0;
    for (int c = 0; c < e; c++)
      if (s_we[c] && s_addr[c] == 5'd3) fnum = s_data[c];
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"},  64'(o_busy), 64'd0);
    chk({tag, ".end"},   64'(o_end),  64'd0);
    chk({tag, ".code"},  64'(o_code), 64'd0);
    chk({tag, ".cyc"},   64'(o_cyc),  64'd0);
    chk({tag, ".fnum"},  64'(o_fn),   64'd0);
    chk({tag, ".trap"},  64'(o_trap), 64'd0);
  endtask

  task automatic release_sel();
    if (sel_r) rst_b = 1'b1; else rst_a = 1'b1;
  endtask

  // Reset both instances, check reset state, release the selected one; ends in run cycle 0.
  task automatic begin_run(input bit sel);
    sel_r = sel; rst_a = 1'b0; rst_b = 1'b0;
    we = 1'b0; mends = 1'b0; addr = 5'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    release_sel();
    @(posedge clk); #1;
  endtask

  // Drive the stimulus table and compare every cycle; optional reset at abort_at.
  task automatic run(input int abort_at);
    int code, e, mode, lim;
    logic [31:0] fnum;
    bit tr, aborted;
    mode = sel_r ? 1 : 0;
    lim  = sel_r ? LIM_B : LIM_A;
    aborted = 1'b0;
    model(mode, lim, code, e, fnum);
    for (int c = 0; c <= e + 1; c++) begin
      we = s_we[c]; addr = s_addr[c]; wdata = s_data[c]; mends = s_m[c];
      if (c == abort_at) begin if (sel_r) rst_b = 1'b0; else rst_a = 1'b0; end
      @(negedge clk);
      tr = 1'b0;
`ifdef TEST_MON_TRAPGEN_EN
      tr = (c >= 900) && (c <= 906) && (c < e);
`endif
      chk($sformatf("busy@%0d", c), 64'(o_busy), 64'(c < e));
      chk($sformatf("end@%0d", c),  64'(o_end),  64'(c == e));
      chk($sformatf("code@%0d", c), 64'(o_code), (c >= e) ? 64'(code) : 64'd0);
      chk($sformatf("cyc@%0d", c),  64'(o_cyc),  (c <= e) ? 64'(c) : 64'(e));
      if (c >= e) chk($sformatf("fnum@%0d", c), 64'(o_fn), 64'(fnum));
      chk($sformatf("trap@%0d", c), 64'(o_trap), 64'(tr));
      @(posedge clk); #1;
      if (c == abort_at) begin aborted = 1'b1; break; end
    end
    we = 1'b0; mends = 1'b0; addr = 5'd0; wdata = 32'd0;
    if (aborted) begin
      @(negedge clk);
      check_zero("midrst");
      release_sel();
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_fill(input int n, input int hi);
    int c, k;
    logic [4:0] a;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      c = int'($urandom_range(hi, 0));
      k = int'($urandom_range(4, 0));
      case (k)
        0: a = 5'd0;  1: a = 5'd3;  2: a = 5'd26;  3: a = 5'd27;
        default: a = 5'($urandom_range(31, 0));
      endcase
      k = int'($urandom_range(3, 0));
      case (k)
        0: d = 32'd0;  1: d = 32'd1;  2: d = 32'd2;
        default: d = $urandom;
      endcase
      wr(c, a, d);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; we = 1'b0; mends = 1'b0; addr = 5'd0; wdata = 32'd0;

    // MODE 0 pass at 500 -> verdict at 511
    clear_stim(); wr(10, 5'd27, 32'd1); wr(200, 5'd3, 32'd9); wr(500, 5'd26, 32'd1);
    begin_run(1'b0); run(-1);

    // MODE 0 fail with test number; earlier done value 2 is ignored
    clear_stim(); wr(20, 5'd3, 32'd5); wr(30, 5'd27, 32'd0);
    wr(40, 5'd26, 32'd2); wr(60, 5'd26, 32'd1);
    begin_run(1'b0); run(-1);

    // result written inside the settle window still counts
    clear_stim(); wr(100, 5'd26, 32'd1); wr(105, 5'd27, 32'd1);
    begin_run(1'b0); run(-1);

    // software end beats a same-cycle done write
    clear_stim(); wr(150, 5'd26, 32'd1); s_m[150] = 1'b1;
    begin_run(1'b0); run(-1);

    // no writes: timeout at 1000 (and trap window when built)
    clear_stim();
    begin_run(1'b0); run(-1);

    // reset during SETTLE, then a fresh pass from counter 0
    clear_stim(); wr(295, 5'd26, 32'd1);
    begin_run(1'b0); run(300);
    clear_stim(); wr(50, 5'd27, 32'd1); wr(80, 5'd26, 32'd1);
    run(-1);

    // randomized MODE 0 runs
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      rand_fill(40, 600);
      if ($urandom_range(1, 0) == 1) wr(int'($urandom_range(500, 100)), 5'd26, 32'd1);
      if ($urandom_range(3, 0) == 0) s_m[int'($urandom_range(700, 50))] = 1'b1;
      begin_run(1'b0); run(-1);
    end

    // MODE 1: mends at the timeout cycle loses to timeout
    clear_stim(); s_m[200] = 1'b1;
    begin_run(1'b1); run(-1);

    // MODE 1: done register ignored, mends at 150 ends the run
    clear_stim(); wr(50, 5'd27, 32'd1); wr(100, 5'd26, 32'd1); s_m[150] = 1'b1;
    begin_run(1'b1); run(-1);

    // MODE 1 randomized
    for (int r = 0; r < 3; r++) begin
      clear_stim();
      rand_fill(30, 190);
      if ($urandom_range(1, 0) == 1) s_m[int'($urandom_range(210, 0))] = 1'b1;
      begin_run(1'b1); run(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
